serial_to_parallel_rx: RTL and testbench

Per-lane receive front end of the PHY. It takes the serial bit stream of one lane, finds byte alignment from the COM idle symbol 0xBC, and qualifies the link after a run of consecutive COM symbols. It then delivers aligned bytes with a valid flag to the byte-unstripping stage, one instance per lane, feeding data_par_N / valid_par_N.

---
 rtl/serial_to_parallel_rx.sv | 157 +++++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - per-lane serial receive front end with COM alignment and link qualification
//
// Purpose: shifts in one serial bit per clk_8f edge (MSB first), finds byte
// alignment from the COM symbol, qualifies the link after BC_TARGET
// consecutive COM symbols and then delivers aligned bytes.
//
// Optional feature macro: RX_LOS_EN (loss of sync after LOS_BYTES consecutive
// non-COM bytes in ACTIVE). Without it ACTIVE is left only by reset.
//
// Ports:
//   clk_8f      in   bit clock, one serial bit sampled per rising edge
//   reset       in   asynchronous active-high reset
//   data_in     in   serial bit, MSB of each byte first
//   data_par    out  [7:0] aligned byte, updated on byte boundaries only
//   valid_par   out  data_par is a non-COM byte received in ACTIVE
//   byte_strobe out  one-cycle pulse when data_par/valid_par update in ACTIVE
//   active      out  link aligned and qualified
module serial_to_parallel_rx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned BC_TARGET = 4,
    parameter int unsigned LOS_BYTES = 64
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_par,
    output logic       valid_par,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_COUNT  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] BC_TGT = 4'(BC_TARGET);

    state_t     state_q, state_d;
    logic [6:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;

`ifdef RX_LOS_EN
    localparam logic [7:0] LOS_TGT = 8'(LOS_BYTES);
    logic [7:0] los_cnt_q, los_cnt_d;
`endif

    // Candidate byte: the seven previously sampled bits plus the bit on the wire now.
    logic [7:0] nb;
    logic       is_com;
    logic       boundary;

    assign nb       = {sr_q, data_in};
    assign is_com   = (nb == COM);
    assign boundary = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SEARCH;
            sr_q      <= 7'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
`ifdef RX_LOS_EN
            los_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
`ifdef RX_LOS_EN
            los_cnt_q <= los_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = nb[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
`ifdef RX_LOS_EN
        los_cnt_d = los_cnt_q;
`endif

        case (state_q)
            ST_SEARCH: begin
                valid_d = 1'b0;
                // Sliding match: any bit offset may complete a COM.
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    bc_cnt_d  = 4'd1;
                    state_d   = (BC_TGT == 4'd1) ? ST_ACTIVE : ST_COUNT;
                end
            end

            ST_COUNT: begin
                valid_d = 1'b0;
                if (boundary) begin
                    if (is_com) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if (bc_cnt_q + 4'd1 == BC_TGT) begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        bc_cnt_d = 4'd0;
                        state_d  = ST_SEARCH;
                    end
                end
            end

            ST_ACTIVE: begin
                if (boundary) begin
                    data_d   = nb;
                    valid_d  = !is_com;
                    strobe_d = 1'b1;
`ifdef RX_LOS_EN
                    // The byte that trips loss of sync is still delivered on this edge.
                    if (is_com) begin
                        los_cnt_d = 8'd0;
                    end else if (los_cnt_q + 8'd1 == LOS_TGT) begin
                        los_cnt_d = 8'd0;
                        bc_cnt_d  = 4'd0;
                        state_d   = ST_SEARCH;
                    end else begin
                        los_cnt_d = los_cnt_q + 8'd1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    assign data_par    = data_q;
    assign valid_par   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - randomized self-checking bench for serial_to_parallel_rx
module tb_serial_to_parallel_rx;

    localparam logic [7:0] COM       = 8'hBC;
    localparam int         BC_TARGET = 4;
    localparam int         LOS_BYTES = 64;

    logic       clk_8f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_par;
    logic       valid_par;
    logic       byte_strobe;
    logic       active;

    serial_to_parallel_rx #(
        .COM       (COM),
        .BC_TARGET (BC_TARGET),
        .LOS_BYTES (LOS_BYTES)
    ) dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_par    (data_par),
        .valid_par   (valid_par),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bit history, alignment phase, COM run length, link flag.
    int         m_hist;
    bit         m_aligned;
    int         m_phase;
    int         m_run;
    bit         m_linked;
    int         m_los;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_strobe;
    int         m_strobes;

    // Observations accumulated while bits are driven.
    int cyc, last_sc, cyc_mis, strobes, vstrobes, per_bad;
    bit seen12;

    function automatic void model_reset();
        m_hist = 0; m_aligned = 0; m_phase = 0; m_run = 0; m_linked = 0; m_los = 0;
        m_data = 8'h00; m_valid = 0; m_strobe = 0;
    endfunction

    function automatic void model_step(input logic b);
        bit was_linked;
        was_linked = m_linked;
        m_hist   = ((m_hist << 1) | int'(b)) & 255;
        m_strobe = 0;
        if (!was_linked) m_valid = 0;
        if (!m_aligned) begin
            if (m_hist == int'(COM)) begin
                m_aligned = 1; m_phase = 0; m_run = 1;
                if (m_run >= BC_TARGET) m_linked = 1;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == 8) begin
                m_phase = 0;
                if (was_linked) begin
                    m_data   = 8'(m_hist);
                    m_valid  = (m_hist != int'(COM));
                    m_strobe = 1;
                    m_strobes++;
                    if (m_hist == int'(COM)) m_los = 0;
                    else m_los++;
`ifdef RX_LOS_EN
                    if (m_los == LOS_BYTES) begin
                        m_linked = 0; m_aligned = 0; m_run = 0; m_los = 0;
                    end
`endif
                end else if (m_hist == int'(COM)) begin
                    m_run++;
                    if (m_run == BC_TARGET) m_linked = 1;
                end else begin
                    m_aligned = 0; m_run = 0;
                end
            end
        end
    endfunction

    task automatic clear_obs();
        cyc_mis = 0; strobes = 0; vstrobes = 0; per_bad = 0; seen12 = 0; m_strobes = 0;
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_8f);
        model_step(b);
        cyc++;
        @(negedge clk_8f);
        if ({data_par, valid_par, byte_strobe, active} !== {m_data, m_valid, m_strobe, m_linked})
            cyc_mis++;
        if (byte_strobe === 1'b1) begin
            strobes++;
            if (valid_par === 1'b1) vstrobes++;
            if (last_sc >= 0 && cyc - last_sc != 8) per_bad++;
            last_sc = cyc;
            if (data_par === 8'h12) seen12 = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk_8f);
        @(negedge clk_8f);
        reset = 1'b0;
        last_sc = -1;
    endtask

    task automatic qualify();
        for (int i = 0; i < BC_TARGET; i++) send_byte(COM);
    endtask

    task automatic test_reset();
        @(negedge clk_8f);
        n_cmp++; if (data_par !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_par); end
        n_cmp++; if (valid_par !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_par); end
        n_cmp++; if (byte_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got=%b exp=0", byte_strobe); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active); end
        do_reset();
    endtask

    task automatic test_sliding();
        do_reset(); clear_obs();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) send_byte(COM);
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL slide_pre_active got=%b exp=0", active); end
        send_byte(COM);
        n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL slide_active got=%b exp=1", active); end
        n_cmp++; if (byte_strobe !== 1'b0) begin n_fail++; $display("FAIL slide_entry_strobe got=%b exp=0", byte_strobe); end
        send_byte(8'h55);
        n_cmp++; if ({data_par, valid_par, byte_strobe} !== {8'h55, 1'b1, 1'b1})
            begin n_fail++; $display("FAIL slide_byte got=%h/%b/%b exp=55/1/1", data_par, valid_par, byte_strobe); end
        send_bit(1'b0);
        n_cmp++; if ({data_par, byte_strobe} !== {8'h55, 1'b0})
            begin n_fail++; $display("FAIL slide_hold got=%h/%b exp=55/0", data_par, byte_strobe); end
        n_cmp++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL slide_model got=%0d exp=0 mismatching cycles", cyc_mis); end
    endtask

    task automatic test_interrupted();
        do_reset(); clear_obs();
        send_byte(COM); send_byte(COM); send_byte(8'h12);
        for (int i = 0; i < 3; i++) send_byte(COM);
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL intr_pre_active got=%b exp=0", active); end
        send_byte(COM);
        n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL intr_active got=%b exp=1", active); end
        send_byte(8'hA7);
        n_cmp++; if ({data_par, valid_par, byte_strobe} !== {8'hA7, 1'b1, 1'b1})
            begin n_fail++; $display("FAIL intr_byte got=%h/%b/%b exp=a7/1/1", data_par, valid_par, byte_strobe); end
        n_cmp++; if (strobes !== 1 || seen12 !== 1'b0)
            begin n_fail++; $display("FAIL intr_strobes got=%0d/%b exp=1/0", strobes, seen12); end
        n_cmp++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL intr_model got=%0d exp=0 mismatching cycles", cyc_mis); end
    endtask

    task automatic test_idle();
        logic [7:0] seq [3];
        logic       vexp [3];
        seq = '{COM, 8'h3C, COM};
        vexp = '{1'b0, 1'b1, 1'b0};
        do_reset(); qualify(); clear_obs();
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i]);
            n_cmp++; if ({data_par, valid_par, byte_strobe} !== {seq[i], vexp[i], 1'b1})
                begin n_fail++; $display("FAIL idle_byte%0d got=%h/%b/%b exp=%h/%b/1", i, data_par, valid_par, byte_strobe, seq[i], vexp[i]); end
        end
        n_cmp++; if (strobes !== 3 || per_bad !== 0)
            begin n_fail++; $display("FAIL idle_period got=%0d strobes %0d bad exp=3/0", strobes, per_bad); end
        n_cmp++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL idle_model got=%0d exp=0 mismatching cycles", cyc_mis); end
    endtask

    task automatic test_async_reset();
        int s0;
        do_reset(); qualify(); send_byte(8'h55); clear_obs();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({data_par, valid_par, byte_strobe, active} !== 11'd0)
            begin n_fail++; $display("FAIL arst_outputs got=%h/%b/%b/%b exp=00/0/0/0", data_par, valid_par, byte_strobe, active); end
        model_reset();
        @(negedge clk_8f);
        reset = 1'b0;
        last_sc = -1;
        s0 = strobes;
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) send_byte(COM);
        send_byte(8'h01);
        n_cmp++; if (strobes !== s0 || active !== 1'b0)
            begin n_fail++; $display("FAIL arst_noqual got=%0d strobes active=%b exp=%0d/0", strobes, active, s0); end
        qualify();
        send_byte(8'h01);
        n_cmp++; if ({data_par, valid_par, byte_strobe, active} !== {8'h01, 1'b1, 1'b1, 1'b1})
            begin n_fail++; $display("FAIL arst_requal got=%h/%b/%b/%b exp=01/1/1/1", data_par, valid_par, byte_strobe, active); end
        n_cmp++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL arst_model got=%0d exp=0 mismatching cycles", cyc_mis); end
    endtask

    task automatic test_los();
        do_reset(); qualify(); clear_obs();
`ifdef RX_LOS_EN
        for (int i = 0; i < LOS_BYTES; i++) begin
            send_byte(8'h00);
            if (i == LOS_BYTES - 2) begin
                n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL los_pre_active got=%b exp=1", active); end
            end
        end
        n_cmp++; if ({active, byte_strobe, valid_par} !== 3'b011)
            begin n_fail++; $display("FAIL los_exit got=%b/%b/%b exp=0/1/1", active, byte_strobe, valid_par); end
        n_cmp++; if (strobes !== LOS_BYTES) begin n_fail++; $display("FAIL los_strobes got=%0d exp=%0d", strobes, LOS_BYTES); end
        qualify();
        n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL los_recover got=%b exp=1", active); end
`else
        for (int i = 0; i < LOS_BYTES + 200; i++) send_byte(8'h00);
        n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL nolos_active got=%b exp=1", active); end
        n_cmp++; if (strobes !== LOS_BYTES + 200 || vstrobes !== LOS_BYTES + 200)
            begin n_fail++; $display("FAIL nolos_strobes got=%0d/%0d exp=%0d", strobes, vstrobes, LOS_BYTES + 200); end
`endif
        n_cmp++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL los_model got=%0d exp=0 mismatching cycles", cyc_mis); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset(); clear_obs();
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_bit(1'($urandom_range(0, 1)));
                end
                if ($urandom_range(0, 1) == 0) send_byte(COM);
                else send_byte(8'($urandom));
            end
            n_cmp++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL rand%0d_model got=%0d exp=0 mismatching cycles", r, cyc_mis); end
            n_cmp++; if (strobes !== m_strobes) begin n_fail++; $display("FAIL rand%0d_strobes got=%0d exp=%0d", r, strobes, m_strobes); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        cyc     = 0;
        last_sc = -1;
        model_reset();
        clear_obs();
        test_reset();
        test_sliding();
        test_interrupted();
        test_idle();
        test_async_reset();
        test_los();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
